// File: rtl/port_scan_cnt.sv
// port_scan_cnt: parametrised port-index scanner with up/down advance, synchronous
// load, skipping of disabled ports and a registered wrap carry.
module port_scan_cnt #(
    parameter int unsigned W     = 2,
    parameter int unsigned NPORT = 4,
    parameter int unsigned TERM  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [W-1:0]     load_val,
    input  logic [NPORT-1:0] mask,
    output logic [W-1:0]     port,
    output logic             co,
    output logic             at_term,
    output logic             valid,
    output logic             none
);

    logic [W-1:0] port_q, port_d;
    logic         co_q, co_d;
    logic [W-1:0] next_port;
    logic         next_wrap;

    // Circular search for the nearest enabled port strictly after port_q in direction dir.
    // Step NPORT lands back on port_q, so a single enabled port returns to itself.
    always_comb begin
        logic found;
        found     = 1'b0;
        next_port = port_q;
        next_wrap = 1'b0;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            int               cand;
            logic             wrap;
            logic [NPORT-1:0] sh;
            cand = dir ? int'(port_q) - int'(k) : int'(port_q) + int'(k);
            wrap = 1'b0;
            if (cand >= int'(NPORT)) begin
                cand = cand - int'(NPORT);
                wrap = 1'b1;
            end else if (cand < 0) begin
                cand = cand + int'(NPORT);
                wrap = 1'b1;
            end
            sh = mask >> cand;
            if (!found && sh[0]) begin
                found     = 1'b1;
                next_port = W'(cand);
                next_wrap = wrap;
            end
        end
    end

    // Next-state: load (even out of range) consumes the cycle, otherwise advance or hold.
    always_comb begin
        port_d = port_q;
        co_d   = 1'b0;
        if (load) begin
            if (32'(load_val) < NPORT) begin
                port_d = load_val;
            end
        end else if (en && (mask != '0)) begin
            port_d = next_port;
            co_d   = next_wrap;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            port_q <= '0;
            co_q   <= 1'b0;
        end else begin
            port_q <= port_d;
            co_q   <= co_d;
        end
    end

    // Status decode straight from the current index and mask.
    always_comb begin
        valid = 1'b0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (port_q == W'(i)) begin
                valid = mask[i];
            end
        end
    end

    assign port    = port_q;
    assign co      = co_q;
    assign at_term = (port_q == W'(TERM));
    assign none    = (mask == '0);

endmodule

// File: tb/tb_port_scan_cnt.sv
// Testbench for port_scan_cnt: directed vector table, corner sequences and random
// stimulus checked against a behavioural model, on a 4-port and a 5-port instance.
module tb_port_scan_cnt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: W=2, NPORT=4, TERM=1
    logic       a_rst, a_en, a_dir, a_load;
    logic [1:0] a_load_val;
    logic [3:0] a_mask;
    logic [1:0] a_port;
    logic       a_co, a_at_term, a_valid, a_none;

    // Instance B: W=3, NPORT=5, TERM=4
    logic       b_rst, b_en, b_dir, b_load;
    logic [2:0] b_load_val;
    logic [4:0] b_mask;
    logic [2:0] b_port;
    logic       b_co, b_at_term, b_valid, b_none;

    port_scan_cnt #(.W(2), .NPORT(4), .TERM(1)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .dir(a_dir), .load(a_load),
        .load_val(a_load_val), .mask(a_mask), .port(a_port), .co(a_co),
        .at_term(a_at_term), .valid(a_valid), .none(a_none)
    );

    port_scan_cnt #(.W(3), .NPORT(5), .TERM(4)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .dir(b_dir), .load(b_load),
        .load_val(b_load_val), .mask(b_mask), .port(b_port), .co(b_co),
        .at_term(b_at_term), .valid(b_valid), .none(b_none)
    );

    int checks = 0;
    int errors = 0;

    int ma_port = 0;
    bit ma_co   = 0;
    int mb_port = 0;
    bit mb_co   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: the enabled ports as a sorted list; up picks the smallest
    // enabled index above the current one, else wraps to the smallest overall.
    task automatic model_next(input int nport, input int p, input logic [7:0] msk,
                              input bit r, input bit e, input bit dr, input bit ld,
                              input int lv, output int np, output bit nc);
        int  ens[$];
        bit  got;
        np  = p;
        nc  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < nport; i++) if (msk[i]) ens.push_back(i);
        if (!r) begin
            np = 0;
        end else if (ld) begin
            if (lv < nport) np = lv;
        end else if (e && ens.size() > 0) begin
            if (!dr) begin
                foreach (ens[j]) if (!got && ens[j] > p) begin np = ens[j]; got = 1'b1; end
                if (!got) begin np = ens[0]; nc = 1'b1; end
            end else begin
                for (int j = ens.size() - 1; j >= 0; j--)
                    if (!got && ens[j] < p) begin np = ens[j]; got = 1'b1; end
                if (!got) begin np = ens[ens.size() - 1]; nc = 1'b1; end
            end
        end
    endtask

    // One clock: advance both models with the inputs present at the edge, then sample.
    task automatic tick(input bit cmp_a, input bit cmp_b);
        int na, nb;
        bit ca, cb;
        model_next(4, ma_port, {4'b0, a_mask}, a_rst, a_en, a_dir, a_load,
                   int'(a_load_val), na, ca);
        model_next(5, mb_port, {3'b0, b_mask}, b_rst, b_en, b_dir, b_load,
                   int'(b_load_val), nb, cb);
        @(posedge clk);
        ma_port = na; ma_co = ca;
        mb_port = nb; mb_co = cb;
        #1;
        if (cmp_a) begin
            chk("a_port", int'(a_port), ma_port);
            chk("a_co", int'(a_co), int'(ma_co));
            chk("a_at_term", int'(a_at_term), int'(ma_port == 1));
            chk("a_valid", int'(a_valid), int'((a_mask >> ma_port) & 4'd1));
            chk("a_none", int'(a_none), int'(a_mask == 4'd0));
        end
        if (cmp_b) begin
            chk("b_port", int'(b_port), mb_port);
            chk("b_co", int'(b_co), int'(mb_co));
            chk("b_at_term", int'(b_at_term), int'(mb_port == 4));
            chk("b_valid", int'(b_valid), int'((b_mask >> mb_port) & 5'd1));
            chk("b_none", int'(b_none), int'(b_mask == 5'd0));
        end
    endtask

    typedef struct {
        bit       rst, en, dir, ld;
        bit [1:0] lv;
        bit [3:0] msk;
        int       ep;
        bit       ec, et, ev, enone;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input bit r, input bit e, input bit d, input bit l, input bit [1:0] lv,
                        input bit [3:0] m, input int ep, input bit ec, input bit et,
                        input bit ev, input bit enone);
        vec_t v;
        v = '{rst: r, en: e, dir: d, ld: l, lv: lv, msk: m, ep: ep, ec: ec, et: et, ev: ev,
              enone: enone};
        vecs.push_back(v);
    endtask

    task automatic set_b(input bit r, input bit e, input bit d, input bit l,
                         input bit [2:0] lv, input bit [4:0] m);
        b_rst = r; b_en = e; b_dir = d; b_load = l; b_load_val = lv; b_mask = m;
    endtask

    initial begin
        a_rst = 0; a_en = 0; a_dir = 0; a_load = 0; a_load_val = 0; a_mask = 4'hF;
        set_b(0, 0, 0, 0, 0, 5'h1F);

        //   rst en dir ld lv mask    port co term valid none
        addv(0, 0, 0, 0, 0, 4'hF,    0, 0, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'hF,    1, 0, 1, 1, 0);
        addv(1, 1, 0, 0, 0, 4'hF,    2, 0, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'hF,    3, 0, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'hF,    0, 1, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'hF,    1, 0, 1, 1, 0);
        addv(1, 0, 0, 1, 1, 4'hA,    1, 0, 1, 1, 0);
        addv(1, 1, 0, 0, 0, 4'hA,    3, 0, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'hA,    1, 1, 1, 1, 0);
        addv(1, 1, 0, 0, 0, 4'hA,    3, 0, 0, 1, 0);
        addv(1, 0, 0, 1, 0, 4'hF,    0, 0, 0, 1, 0);
        addv(1, 1, 1, 0, 0, 4'hF,    3, 1, 0, 1, 0);
        addv(1, 1, 1, 0, 0, 4'hF,    2, 0, 0, 1, 0);
        addv(1, 1, 0, 1, 2, 4'hF,    2, 0, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'h0,    2, 0, 0, 0, 1);
        addv(1, 1, 0, 0, 0, 4'h4,    2, 1, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'h4,    2, 1, 0, 1, 0);
        addv(1, 1, 1, 0, 0, 4'h4,    2, 1, 0, 1, 0);
        addv(1, 0, 0, 1, 3, 4'hF,    3, 0, 0, 1, 0);
        addv(0, 1, 0, 0, 0, 4'hF,    0, 0, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'hE,    1, 0, 1, 1, 0);
        addv(0, 1, 0, 0, 0, 4'hE,    0, 0, 0, 0, 0);
        addv(1, 1, 1, 0, 0, 4'h1,    0, 1, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'h9,    3, 0, 0, 1, 0);
        addv(1, 1, 0, 0, 0, 4'h9,    0, 1, 0, 1, 0);

        foreach (vecs[i]) begin
            a_rst = vecs[i].rst; a_en = vecs[i].en; a_dir = vecs[i].dir;
            a_load = vecs[i].ld; a_load_val = vecs[i].lv; a_mask = vecs[i].msk;
            tick(0, 0);
            chk($sformatf("vec%0d_port", i), int'(a_port), vecs[i].ep);
            chk($sformatf("vec%0d_co", i), int'(a_co), int'(vecs[i].ec));
            chk($sformatf("vec%0d_at_term", i), int'(a_at_term), int'(vecs[i].et));
            chk($sformatf("vec%0d_valid", i), int'(a_valid), int'(vecs[i].ev));
            chk($sformatf("vec%0d_none", i), int'(a_none), int'(vecs[i].enone));
        end

        // Reset pulsed low between edges must have no asynchronous effect.
        a_rst = 1; a_en = 0; a_load = 1; a_load_val = 2; a_mask = 4'hF;
        tick(0, 0);
        chk("glitch_pre_port", int'(a_port), 2);
        a_load = 0;
        #2 a_rst = 0;
        #2 chk("glitch_mid_port", int'(a_port), 2);
        #1 a_rst = 1;
        tick(0, 0);
        chk("glitch_post_port", int'(a_port), 2);
        chk("glitch_post_co", int'(a_co), 0);

        // Instance B: out-of-range loads are consumed, wrap at NPORT-1 with NPORT < 2**W.
        set_b(0, 0, 0, 0, 0, 5'h1F);  tick(0, 0);
        chk("b_rst_port", int'(b_port), 0);
        set_b(1, 0, 0, 1, 2, 5'h1F);  tick(0, 0);
        chk("b_load2_port", int'(b_port), 2);
        set_b(1, 1, 0, 1, 5, 5'h1F);  tick(0, 0);
        chk("b_load5_port", int'(b_port), 2);
        chk("b_load5_co", int'(b_co), 0);
        set_b(1, 1, 0, 1, 7, 5'h1F);  tick(0, 0);
        chk("b_load7_port", int'(b_port), 2);
        set_b(1, 1, 0, 0, 0, 5'h1F);  tick(0, 0);
        chk("b_up_port3", int'(b_port), 3);
        tick(0, 0);
        chk("b_up_port4", int'(b_port), 4);
        chk("b_up_term", int'(b_at_term), 1);
        tick(0, 0);
        chk("b_wrap_port", int'(b_port), 0);
        chk("b_wrap_co", int'(b_co), 1);
        b_dir = 1; tick(0, 0);
        chk("b_down_port", int'(b_port), 4);
        chk("b_down_co", int'(b_co), 1);

        // Randomised stimulus on both instances against the model.
        a_rst = 0; b_rst = 0; a_load = 0; b_load = 0;
        tick(1, 1);
        for (int n = 0; n < 500; n++) begin
            int sel;
            a_rst = ($urandom_range(0, 24) != 0);
            a_en = ($urandom_range(0, 3) != 0);
            a_dir = 1'($urandom_range(0, 1));
            a_load = ($urandom_range(0, 7) == 0);
            a_load_val = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 7));
            if (sel == 0) a_mask = 4'h0;
            else if (sel == 1) a_mask = 4'(1 << $urandom_range(0, 3));
            else a_mask = 4'($urandom_range(0, 15));
            b_rst = ($urandom_range(0, 24) != 0);
            b_en = ($urandom_range(0, 3) != 0);
            b_dir = 1'($urandom_range(0, 1));
            b_load = ($urandom_range(0, 7) == 0);
            b_load_val = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 7));
            if (sel == 0) b_mask = 5'h0;
            else if (sel == 1) b_mask = 5'(1 << $urandom_range(0, 4));
            else b_mask = 5'($urandom_range(0, 31));
            tick(1, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
